tag_ram_multiway: RTL

Parametrised multi-way tag store for the cache subsystem: WAYS independent banks of 2^AWIDTH entries, DWIDTH bits each, with registered synchronous read of all ways at one index and single-way write. A built-in sweep FSM zeroes every entry after reset or on request, so no preload file is needed. The block replaces the single-bank tag RAMs feeding the tag-compare stage.

---
 rtl/tag_ram_pkg.sv | 24 ++
 rtl/tag_ram_way.sv | 86 ++++++++
 rtl/tag_ram_multiway.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/tag_ram_pkg.sv
// Shared types and helpers for the multi-way tag RAM.
// Optional parity storage is selected with TAG_RAM_PARITY_EN.
package tag_ram_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        IDLE = 1'b1
    } tag_state_e;

    // Way-select width: a single-way store still carries a 1-bit selector.
    function automatic int wbits_f(input int ways);
        if (ways <= 2) begin
            return 1;
        end else begin
            return $clog2(ways);
        end
    endfunction

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic even_parity_f(input logic [63:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/tag_ram_way.sv
// One tag bank: synchronous write, registered read with write-first bypass.
// With TAG_RAM_PARITY_EN each entry carries an even-parity bit above the tag.
module tag_ram_way
    import tag_ram_pkg::*;
#(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 7
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic [DWIDTH-1:0] rd_data
`ifdef TAG_RAM_PARITY_EN
    ,
    output logic              par_err
`endif
);

    localparam int DEPTH = 1 << AWIDTH;
`ifdef TAG_RAM_PARITY_EN
    localparam int EWIDTH = DWIDTH + 1;
`else
    localparam int EWIDTH = DWIDTH;
`endif

    logic [EWIDTH-1:0] mem_r [DEPTH];
    logic [EWIDTH-1:0] wr_word_s;
    logic [EWIDTH-1:0] rd_word_s;
    logic [DWIDTH-1:0] rd_data_r;

    // Build the stored word from the incoming tag.
    always_comb begin
`ifdef TAG_RAM_PARITY_EN
        wr_word_s = {even_parity_f(64'(wr_data)), wr_data};
`else
        wr_word_s = wr_data;
`endif
    end

    // Write-first: a same-index write in this cycle overrides the array.
    always_comb begin
        if (wr_en && (wr_addr == rd_addr)) begin
            rd_word_s = wr_word_s;
        end else begin
            rd_word_s = mem_r[rd_addr];
        end
    end

    // Storage array; cleared by the owner's sweep rather than by reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_word_s;
        end
    end

    // Read data register holds its value between reads.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_r <= '0;
        end else if (rd_en) begin
            rd_data_r <= rd_word_s[DWIDTH-1:0];
        end
    end

    assign rd_data = rd_data_r;

`ifdef TAG_RAM_PARITY_EN
    logic par_err_r;

    // Parity check flag, aligned with the read data register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            par_err_r <= 1'b0;
        end else begin
            par_err_r <= rd_en & (^rd_word_s);
        end
    end

    assign par_err = par_err_r;
`endif

endmodule

// File: rtl/tag_ram_multiway.sv
// Multi-way tag store: WAYS banks, all-way read, single-way write, clear sweep.
// Optional per-entry parity and par_err output with TAG_RAM_PARITY_EN.
module tag_ram_multiway
    import tag_ram_pkg::*;
#(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 7,
    parameter int WAYS   = 2,
    localparam int WBITS = wbits_f(WAYS)
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    init_req,
    output logic                    busy,
    input  logic                    rd_en,
    input  logic [AWIDTH-1:0]       rd_addr,
    output logic                    rd_valid,
    output logic [WAYS*DWIDTH-1:0]  rd_data,
    input  logic                    wr_en,
    input  logic [AWIDTH-1:0]       wr_addr,
    input  logic [WBITS-1:0]        wr_way,
    input  logic [DWIDTH-1:0]       wr_data
`ifdef TAG_RAM_PARITY_EN
    ,
    output logic                    par_err
`endif
);

    localparam int DEPTH = 1 << AWIDTH;
    localparam logic [AWIDTH-1:0] LAST_IDX = AWIDTH'(DEPTH - 1);

    tag_state_e        state_r;
    tag_state_e        state_s;
    logic [AWIDTH-1:0] cnt_r;
    logic              busy_r;
    logic              rd_valid_r;
    logic              sweep_s;
    logic              rd_acc_s;
    logic              wr_acc_s;
    logic [AWIDTH-1:0] bank_addr_s;
    logic [DWIDTH-1:0] bank_data_s;
    logic [WAYS-1:0]   way_we_s;

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= INIT;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state: sweep runs to the last index, restart only from IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            INIT: begin
                if (cnt_r == LAST_IDX) begin
                    state_s = IDLE;
                end else begin
                    state_s = INIT;
                end
            end
            IDLE: begin
                if (init_req) begin
                    state_s = INIT;
                end else begin
                    state_s = IDLE;
                end
            end
            default: state_s = INIT;
        endcase
    end

    // FSM outputs: sweep writes while clearing, user traffic only when idle.
    always_comb begin
        sweep_s  = 1'b0;
        rd_acc_s = 1'b0;
        wr_acc_s = 1'b0;
        case (state_r)
            INIT: sweep_s = 1'b1;
            IDLE: begin
                rd_acc_s = rd_en;
                wr_acc_s = wr_en;
            end
            default: sweep_s = 1'b1;
        endcase
    end

    // Sweep index register; wraps to zero after the final entry.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= '0;
        end else if (state_r == INIT) begin
            cnt_r <= cnt_r + AWIDTH'(1'b1);
        end else if (init_req) begin
            cnt_r <= '0;
        end
    end

    // Registered status outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_r     <= 1'b1;
            rd_valid_r <= 1'b0;
        end else begin
            busy_r     <= (state_s == INIT);
            rd_valid_r <= rd_acc_s;
        end
    end

    assign busy     = busy_r;
    assign rd_valid = rd_valid_r;

    // Shared write port: sweep zeroes all ways, otherwise the user port.
    always_comb begin
        if (sweep_s) begin
            bank_addr_s = cnt_r;
            bank_data_s = '0;
        end else begin
            bank_addr_s = wr_addr;
            bank_data_s = wr_data;
        end
    end

`ifdef TAG_RAM_PARITY_EN
    logic [WAYS-1:0] way_perr_s;
    assign par_err = |way_perr_s;
`endif

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        // An out-of-range wr_way never matches any bank and is dropped.
        assign way_we_s[w] = sweep_s | (wr_acc_s & (wr_way == WBITS'(w)));

        tag_ram_way #(
            .AWIDTH (AWIDTH),
            .DWIDTH (DWIDTH)
        ) u_way (
            .clock   (clock),
            .reset_n (reset_n),
            .wr_en   (way_we_s[w]),
            .wr_addr (bank_addr_s),
            .wr_data (bank_data_s),
            .rd_en   (rd_acc_s),
            .rd_addr (rd_addr),
            .rd_data (rd_data[w*DWIDTH +: DWIDTH])
`ifdef TAG_RAM_PARITY_EN
            ,
            .par_err (way_perr_s[w])
`endif
        );
    end

endmodule
